// File: rtl/pacote_rastreio.sv
// Shared definitions for the trace buffer: FSM encodings, motivo bit positions
// and the packed entry width derived from the capture parameters.
package pacote_rastreio;

    typedef enum logic [1:0] {
        OCIOSO    = 2'b00,
        CAPTURA   = 2'b01,
        CONGELADO = 2'b10,
        DESCARGA  = 2'b11
    } estado_t;

    localparam int MOTIVO_HALT    = 0;
    localparam int MOTIVO_LIMITE  = 1;
    localparam int LARGURA_REGESC = 3;
    localparam int LARGURA_CICLOS = 16;

    // Entry layout, MSB to LSB: {PC, instrucao, EscReg, RegEsc, DadoEscr, Halt}.
    function automatic int largura_entrada(input int largura_pc,
                                           input int largura_instr,
                                           input int largura_dado);
        return largura_pc + largura_instr + largura_dado + LARGURA_REGESC + 2;
    endfunction

endpackage

// File: rtl/memoria_rastreio.sv
// Trace storage: PROFUNDIDADE entries, one synchronous write port and one
// combinational read port.
module memoria_rastreio #(
    parameter int PROFUNDIDADE  = 16,
    parameter int LARGURA       = 36,
    parameter int LARGURA_END   = $clog2(PROFUNDIDADE)
) (
    input  logic                   clock,
    input  logic                   esc_en_i,
    input  logic [LARGURA_END-1:0] end_esc_i,
    input  logic [LARGURA-1:0]     dado_esc_i,
    input  logic [LARGURA_END-1:0] end_leit_i,
    output logic [LARGURA-1:0]     dado_leit_o
);

    logic [LARGURA-1:0] mem_q [PROFUNDIDADE];

    // NOTE: the array has no reset; occupancy and pointers in the parent decide
    // which words are valid, so stale contents are never presented.
    always_ff @(posedge clock) begin
        if (esc_en_i) begin
            mem_q[end_esc_i] <= dado_esc_i;
        end
    end

    assign dado_leit_o = mem_q[end_leit_i];

endmodule

// File: rtl/buffer_rastreio.sv
// Processor trace buffer: captures per-cycle probe signals into a circular
// buffer, freezes on Halt or a cycle limit, then dumps oldest-first over a
// valid/ready handshake. Define BUFFER_RASTREIO_FILTRO_EN to store only cycles
// with EscReg or Halt asserted.
module buffer_rastreio
    import pacote_rastreio::*;
#(
    parameter int LARGURA_PC    = 8,
    parameter int LARGURA_INSTR = 16,
    parameter int LARGURA_DADO  = 8,
    parameter int PROFUNDIDADE  = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            armar,
    input  logic [15:0]                     limite,
    input  logic                            descarga,
    input  logic [LARGURA_PC-1:0]           PC,
    input  logic [LARGURA_INSTR-1:0]        instrucao,
    input  logic                            EscReg,
    input  logic [2:0]                      RegEsc,
    input  logic [LARGURA_DADO-1:0]         DadoEscr,
    input  logic                            Halt,
    output logic                            saida_valida,
    input  logic                            saida_pronta,
    output logic [LARGURA_PC-1:0]           saida_PC,
    output logic [LARGURA_INSTR-1:0]        saida_instrucao,
    output logic                            saida_EscReg,
    output logic [2:0]                      saida_RegEsc,
    output logic [LARGURA_DADO-1:0]         saida_DadoEscr,
    output logic                            saida_Halt,
    output logic [1:0]                      estado,
    output logic [$clog2(PROFUNDIDADE):0]   ocupacao,
    output logic [15:0]                     ciclos,
    output logic [1:0]                      motivo
);

    localparam int LARG_END = $clog2(PROFUNDIDADE);
    localparam int LARG_ENT = largura_entrada(LARGURA_PC, LARGURA_INSTR, LARGURA_DADO);
    localparam logic [LARG_END:0] OCUP_MAX = (LARG_END + 1)'(PROFUNDIDADE);

    estado_t                     estado_q, estado_d;
    logic [LARG_END-1:0]         ptr_esc_q, ptr_esc_d;
    logic [LARG_END-1:0]         ptr_leit_q, ptr_leit_d;
    logic [LARG_END:0]           ocupacao_q, ocupacao_d;
    logic [LARGURA_CICLOS-1:0]   ciclos_q, ciclos_d;
    logic [1:0]                  motivo_q, motivo_d;

    logic                        esc_en;
    logic                        inicia;
    logic                        halt_hit;
    logic                        limite_hit;
    logic [LARGURA_CICLOS:0]     ciclos_prox;
    logic [LARG_ENT-1:0]         entrada_esc;
    logic [LARG_ENT-1:0]         entrada_leit;
    logic [LARG_ENT-1:0]         entrada_saida;

    assign entrada_esc = {PC, instrucao, EscReg, RegEsc, DadoEscr, Halt};
    assign ciclos_prox = {1'b0, ciclos_q} + 17'd1;

    // NOTE: every signal driven here gets its default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        estado_d   = estado_q;
        ptr_esc_d  = ptr_esc_q;
        ptr_leit_d = ptr_leit_q;
        ocupacao_d = ocupacao_q;
        ciclos_d   = ciclos_q;
        motivo_d   = motivo_q;
        esc_en     = 1'b0;
        halt_hit   = 1'b0;
        limite_hit = 1'b0;
        inicia     = armar && (estado_q == OCIOSO || estado_q == CONGELADO);

        case (estado_q)
            CAPTURA: begin
`ifdef BUFFER_RASTREIO_FILTRO_EN
                esc_en = EscReg | Halt;
`else
                esc_en = 1'b1;
`endif
                if (esc_en) begin
                    ptr_esc_d = ptr_esc_q + LARG_END'(1);
                    if (ocupacao_q != OCUP_MAX) begin
                        ocupacao_d = ocupacao_q + (LARG_END + 1)'(1);
                    end
                end
                if (ciclos_q != 16'hFFFF) begin
                    ciclos_d = ciclos_prox[LARGURA_CICLOS-1:0];
                end
                halt_hit   = Halt;
                limite_hit = (limite != 16'd0) && (ciclos_prox == {1'b0, limite});
                if (halt_hit || limite_hit) begin
                    estado_d = CONGELADO;
                    motivo_d[MOTIVO_HALT]   = halt_hit;
                    motivo_d[MOTIVO_LIMITE] = limite_hit;
                end
            end
            CONGELADO: begin
                if (!armar && descarga) begin
                    if (ocupacao_q == '0) begin
                        estado_d = OCIOSO;
                    end else begin
                        estado_d   = DESCARGA;
                        // Oldest entry sits ocupacao slots behind the write pointer.
                        ptr_leit_d = ptr_esc_q - ocupacao_q[LARG_END-1:0];
                    end
                end
            end
            DESCARGA: begin
                if (saida_pronta) begin
                    ptr_leit_d = ptr_leit_q + LARG_END'(1);
                    ocupacao_d = ocupacao_q - (LARG_END + 1)'(1);
                    if (ocupacao_q == (LARG_END + 1)'(1)) begin
                        estado_d = OCIOSO;
                    end
                end
            end
            default: ;
        endcase

        if (inicia) begin
            estado_d   = CAPTURA;
            ptr_esc_d  = '0;
            ocupacao_d = '0;
            ciclos_d   = '0;
            motivo_d   = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            ptr_esc_q  <= '0;
            ptr_leit_q <= '0;
            ocupacao_q <= '0;
            ciclos_q   <= '0;
            motivo_q   <= '0;
        end else begin
            estado_q   <= estado_d;
            ptr_esc_q  <= ptr_esc_d;
            ptr_leit_q <= ptr_leit_d;
            ocupacao_q <= ocupacao_d;
            ciclos_q   <= ciclos_d;
            motivo_q   <= motivo_d;
        end
    end

    memoria_rastreio #(
        .PROFUNDIDADE (PROFUNDIDADE),
        .LARGURA      (LARG_ENT),
        .LARGURA_END  (LARG_END)
    ) u_memoria (
        .clock       (clock),
        .esc_en_i    (esc_en),
        .end_esc_i   (ptr_esc_q),
        .dado_esc_i  (entrada_esc),
        .end_leit_i  (ptr_leit_q),
        .dado_leit_o (entrada_leit)
    );

    assign saida_valida  = (estado_q == DESCARGA);
    assign entrada_saida = saida_valida ? entrada_leit : '0;
    assign {saida_PC, saida_instrucao, saida_EscReg, saida_RegEsc,
            saida_DadoEscr, saida_Halt} = entrada_saida;

    assign estado   = estado_q;
    assign ocupacao = ocupacao_q;
    assign ciclos   = ciclos_q;
    assign motivo   = motivo_q;

endmodule

// File: tb/tb_buffer_rastreio.sv
// Self-checking bench for buffer_rastreio: directed scenarios plus randomized
// captures, checked against a queue-based model of the trace buffer.
module tb_buffer_rastreio;

    localparam int PROF = 16;
`ifdef BUFFER_RASTREIO_FILTRO_EN
    localparam bit FILTRO = 1'b1;
`else
    localparam bit FILTRO = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] ins;
        logic        esc;
        logic [2:0]  rg;
        logic [7:0]  dd;
        logic        hl;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        armar = 1'b0;
    logic [15:0] limite = '0;
    logic        descarga = 1'b0;
    logic [7:0]  PC = '0;
    logic [15:0] instrucao = '0;
    logic        EscReg = 1'b0;
    logic [2:0]  RegEsc = '0;
    logic [7:0]  DadoEscr = '0;
    logic        Halt = 1'b0;
    logic        saida_valida;
    logic        saida_pronta = 1'b0;
    logic [7:0]  saida_PC;
    logic [15:0] saida_instrucao;
    logic        saida_EscReg;
    logic [2:0]  saida_RegEsc;
    logic [7:0]  saida_DadoEscr;
    logic        saida_Halt;
    logic [1:0]  estado;
    logic [4:0]  ocupacao;
    logic [15:0] ciclos;
    logic [1:0]  motivo;

    buffer_rastreio dut (
        .clock(clock), .reset(reset), .armar(armar), .limite(limite),
        .descarga(descarga), .PC(PC), .instrucao(instrucao), .EscReg(EscReg),
        .RegEsc(RegEsc), .DadoEscr(DadoEscr), .Halt(Halt),
        .saida_valida(saida_valida), .saida_pronta(saida_pronta),
        .saida_PC(saida_PC), .saida_instrucao(saida_instrucao),
        .saida_EscReg(saida_EscReg), .saida_RegEsc(saida_RegEsc),
        .saida_DadoEscr(saida_DadoEscr), .saida_Halt(saida_Halt),
        .estado(estado), .ocupacao(ocupacao), .ciclos(ciclos), .motivo(motivo)
    );

    always #5 clock = ~clock;

    int   n_assert = 0;
    int   n_fail   = 0;
    ent_t m_q[$];
    int   m_ciclos = 0;
    int   m_lim    = 0;
    int   m_motivo = 0;
    bit   ruido    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic arm(input int lim);
        armar  = 1'b1;
        limite = 16'(lim);
        step();
        armar  = 1'b0;
        m_lim = lim; m_ciclos = 0; m_motivo = 0;
        m_q.delete();
        chk("arm_estado", 32'(estado), 32'd1);
        chk("arm_ocup", 32'(ocupacao), 32'd0);
        chk("arm_ciclos", 32'(ciclos), 32'd0);
        chk("arm_motivo", 32'(motivo), 32'd0);
    endtask

    task automatic cap(input ent_t e, output bit frz);
        bit lim_hit;
        PC = e.pc; instrucao = e.ins; EscReg = e.esc; RegEsc = e.rg;
        DadoEscr = e.dd; Halt = e.hl;
        armar = ruido ? 1'($urandom_range(0, 1)) : 1'b0;
        if (!FILTRO || e.esc || e.hl) begin
            m_q.push_back(e);
            if (m_q.size() > PROF) void'(m_q.pop_front());
        end
        lim_hit = (m_lim != 0) && (m_ciclos + 1 == m_lim);
        if (m_ciclos < 65535) m_ciclos++;
        frz = e.hl || lim_hit;
        if (frz) m_motivo = {30'd0, lim_hit, e.hl};
        step();
        armar = 1'b0; Halt = 1'b0; EscReg = 1'b0;
        chk("cap_estado", 32'(estado), frz ? 32'd2 : 32'd1);
        chk("cap_ocup", 32'(ocupacao), 32'(m_q.size()));
        chk("cap_ciclos", 32'(ciclos), 32'(m_ciclos));
        if (frz) chk("cap_motivo", 32'(motivo), 32'(m_motivo));
    endtask

    // modo 0: always ready; 1: ready pattern 1,0,0,1,1 repeating; 2: random ready and armar noise
    task automatic dump(input int modo);
        int guard;
        int k;
        ent_t e;
        descarga = 1'b1;
        step();
        descarga = 1'b0;
        chk("dump_entra", 32'(estado), (m_q.size() > 0) ? 32'd3 : 32'd0);
        guard = 0;
        k = 0;
        while (m_q.size() > 0 && guard < 200) begin
            e = m_q[0];
            chk("dump_valida", 32'(saida_valida), 32'd1);
            chk("dump_ocup", 32'(ocupacao), 32'(m_q.size()));
            chk("dump_entry", 32'({saida_PC, saida_instrucao}), 32'({e.pc, e.ins}));
            chk("dump_resto", 32'({saida_EscReg, saida_RegEsc, saida_DadoEscr, saida_Halt}),
                32'({e.esc, e.rg, e.dd, e.hl}));
            case (modo)
                0: saida_pronta = 1'b1;
                1: saida_pronta = (k % 5 == 0) || (k % 5 == 3) || (k % 5 == 4);
                default: begin
                    saida_pronta = 1'($urandom_range(0, 1));
                    armar        = 1'($urandom_range(0, 1));
                end
            endcase
            if (saida_pronta) void'(m_q.pop_front());
            step();
            guard++;
            k++;
        end
        saida_pronta = 1'b0;
        armar = 1'b0;
        chk("dump_no_timeout", 32'(guard < 200), 32'd1);
        chk("dump_fim_estado", 32'(estado), 32'd0);
        chk("dump_fim_valida", 32'(saida_valida), 32'd0);
        chk("dump_fim_pc", 32'(saida_PC), 32'd0);
        chk("dump_fim_motivo", 32'(motivo), 32'(m_motivo));
    endtask

    function automatic ent_t mk(input int pc, input bit esc, input bit hl);
        ent_t e;
        e.pc  = 8'(pc);
        e.ins = 16'($urandom);
        e.esc = esc;
        e.rg  = 3'($urandom);
        e.dd  = 8'($urandom);
        e.hl  = hl;
        return e;
    endfunction

    initial begin
        bit frz;
        int lim;
        int nb;

        // Reset state
        reset = 1'b1;
        #12;
        chk("rst_estado", 32'(estado), 32'd0);
        chk("rst_valida", 32'(saida_valida), 32'd0);
        chk("rst_ocup", 32'(ocupacao), 32'd0);
        chk("rst_ciclos", 32'(ciclos), 32'd0);
        chk("rst_motivo", 32'(motivo), 32'd0);
        reset = 1'b0;
        step();

        // Halt-terminated capture of PC 0..4, full dump
        arm(0);
        for (int i = 0; i < 5; i++) cap(mk(i, 1'b1, i == 4), frz);
        if (!FILTRO) begin
            chk("halt5_ocup", 32'(ocupacao), 32'd5);
            chk("halt5_motivo", 32'(motivo), 32'd1);
        end
        dump(0);

        // Cycle limit with wrap: 20 captures into 16 slots
        arm(20);
        for (int i = 0; i < 20; i++) cap(mk(i, 1'b1, 1'b0), frz);
        chk("lim20_estado", 32'(estado), 32'd2);
        chk("lim20_ciclos", 32'(ciclos), 32'd20);
        chk("lim20_ocup", 32'(ocupacao), 32'd16);
        chk("lim20_motivo", 32'(motivo), 32'd2);
        dump(0);

        // Both freeze reasons at once, then re-arm from CONGELADO
        arm(3);
        for (int i = 0; i < 3; i++) cap(mk(i + 40, 1'b1, i == 2), frz);
        chk("both_motivo", 32'(motivo), 32'd3);
        chk("both_ocup", 32'(ocupacao), 32'd3);
        arm(0);

        // Ready pattern 1,0,0,1,1 over five entries
        for (int i = 0; i < 5; i++) cap(mk(i + 60, 1'b1, i == 4), frz);
        dump(1);

        // Reset between edges in the middle of a dump
        arm(0);
        for (int i = 0; i < 6; i++) cap(mk(i + 80, 1'b1, i == 5), frz);
        descarga = 1'b1;
        step();
        descarga = 1'b0;
        saida_pronta = 1'b1;
        step();
        saida_pronta = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("midrst_estado", 32'(estado), 32'd0);
        chk("midrst_valida", 32'(saida_valida), 32'd0);
        chk("midrst_ocup", 32'(ocupacao), 32'd0);
        chk("midrst_pc", 32'(saida_PC), 32'd0);
        #1 reset = 1'b0;
        m_q.delete(); m_ciclos = 0; m_motivo = 0;
        step();
        arm(0);
        for (int i = 0; i < 2; i++) cap(mk(i + 100, 1'b1, i == 1), frz);
        dump(0);

`ifdef BUFFER_RASTREIO_FILTRO_EN
        // Filtered capture: only EscReg or Halt cycles are stored
        arm(0);
        cap(mk(1, 1'b1, 1'b0), frz);
        cap(mk(2, 1'b0, 1'b0), frz);
        cap(mk(3, 1'b0, 1'b0), frz);
        cap(mk(4, 1'b1, 1'b0), frz);
        cap(mk(5, 1'b0, 1'b0), frz);
        cap(mk(6, 1'b0, 1'b1), frz);
        chk("filt_ocup", 32'(ocupacao), 32'd3);
        chk("filt_ciclos", 32'(ciclos), 32'd6);
        dump(0);
        // Limit reached with nothing stored: dump request returns straight to idle
        arm(2);
        cap(mk(7, 1'b0, 1'b0), frz);
        cap(mk(8, 1'b0, 1'b0), frz);
        dump(0);
`endif

        // Randomized rounds with armar noise during capture and dump
        ruido = 1'b1;
        for (int r = 0; r < 8; r++) begin
            lim = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
            arm(lim);
            nb = 0;
            frz = 1'b0;
            while (!frz && nb < 60) begin
                cap(mk(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 29) == 0) || (nb == 59)), frz);
                nb++;
            end
            dump(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
